rr_grant_arbiter: RTL and testbench

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_grant_arbiter.sv | 110 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - four-way round-robin grant arbiter with bounded hold and forced-release timeout
module rr_grant_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gidx_q, gidx_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [1:0] scan_idx;
    logic       hold_expired;
    logic       grantee_req;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        scan_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign hold_expired = (hold_q == HOLD_LAST);
    assign grantee_req  = req[gidx_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = 4'b0001 << pick_idx;
                    gidx_d  = pick_idx;
                    hold_d  = 8'd0;
                end
            end
            ST_GRANT: begin
                if (done || !grantee_req || hold_expired) begin
                    state_d   = ST_IDLE;
                    gnt_d     = 4'b0000;
                    ptr_d     = gidx_q + 2'd1;
                    hold_d    = 8'd0;
                    // Timeout only flags releases that nothing else would have caused.
                    timeout_d = hold_expired && !done && grantee_req;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            gidx_q    <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

    gnt_onehot0_a: assert property (@(posedge clk) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req1;
    logic       done, done1;
    logic [3:0] gnt, gnt1;
    logic       gnt_valid, gnt_valid1;
    logic       timeout, timeout1;

    int n_checks = 0;
    int n_pass   = 0;

    rr_grant_arbiter #(.HOLD_MAX(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_grant_arbiter #(.HOLD_MAX(1)) dut_h1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .done      (done1),
        .gnt       (gnt1),
        .gnt_valid (gnt_valid1),
        .timeout   (timeout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] rot_exp [5];

    initial begin
        rst = 1'b1; req = 4'b0; done = 1'b0; req1 = 4'b0; done1 = 1'b0;
        rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
        rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;

        step(); step();
        check("rst_gnt", 8'(gnt), 8'h00);
        check("rst_valid", 8'(gnt_valid), 8'h00);
        check("rst_timeout", 8'(timeout), 8'h00);
        rst = 1'b0;

        // req=1010 with done one cycle after each grant
        req = 4'b1010;
        step(); check("alt_g0", 8'(gnt), 8'b0010); check("alt_v0", 8'(gnt_valid), 8'h01);
        done = 1'b1;
        step(); check("alt_z0", 8'(gnt), 8'h00); check("alt_vz", 8'(gnt_valid), 8'h00);
        done = 1'b0;
        step(); check("alt_g1", 8'(gnt), 8'b1000);
        done = 1'b1;
        step(); check("alt_z1", 8'(gnt), 8'h00);
        done = 1'b0;
        step(); check("alt_g2", 8'(gnt), 8'b0010);
        done = 1'b1;
        step(); check("alt_z2", 8'(gnt), 8'h00);
        done = 1'b0; req = 4'b0;
        step(); check("idle_hold", 8'(gnt), 8'h00);

        // all requesting: rotation with a zero frame between grants
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            done = 1'b0;
            step(); check($sformatf("rot_g%0d", i), 8'(gnt), 8'(rot_exp[i]));
            done = 1'b1;
            step(); check($sformatf("rot_z%0d", i), 8'(gnt), 8'h00);
        end
        done = 1'b0; req = 4'b0;

        // HOLD_MAX forced release
        do_reset();
        req = 4'b0100;
        step(); check("hold_g1", 8'(gnt), 8'b0100);
        for (int i = 2; i <= 15; i++) begin
            step();
            check($sformatf("hold_g%0d", i), 8'(gnt), 8'b0100);
            check($sformatf("hold_t%0d", i), 8'(timeout), 8'h00);
        end
        step(); check("hold_rel", 8'(gnt), 8'h00); check("hold_to", 8'(timeout), 8'h01);
        step(); check("hold_regnt", 8'(gnt), 8'b0100); check("hold_to_off", 8'(timeout), 8'h00);
        req = 4'b0;
        step(); check("hold_drop", 8'(gnt), 8'h00); check("hold_drop_to", 8'(timeout), 8'h00);

        // grantee drops while req[0] rises; ptr wraps 3 -> 0
        do_reset();
        req = 4'b0100;
        step(); check("drop_g", 8'(gnt), 8'b0100);
        req = 4'b0001;
        step(); check("drop_z", 8'(gnt), 8'h00); check("drop_to", 8'(timeout), 8'h00);
        step(); check("drop_wrap", 8'(gnt), 8'b0001);
        req = 4'b0;
        step();

        // done coincides with hold reaching HOLD_MAX-1
        do_reset();
        req = 4'b0100;
        step();
        for (int i = 2; i <= 15; i++) step();
        check("coin_g15", 8'(gnt), 8'b0100);
        done = 1'b1;
        step(); check("coin_z", 8'(gnt), 8'h00); check("coin_to", 8'(timeout), 8'h00);
        done = 1'b0; req = 4'b0;
        step();

        // reset mid-grant
        do_reset();
        req = 4'b1000;
        step(); check("mid_g", 8'(gnt), 8'b1000);
        rst = 1'b1; req = 4'b1001;
        step(); check("mid_z", 8'(gnt), 8'h00); check("mid_to", 8'(timeout), 8'h00);
        rst = 1'b0;
        step(); check("mid_first", 8'(gnt), 8'b0001);
        req = 4'b0;
        step();

        // done in IDLE is ignored
        do_reset();
        done = 1'b1;
        step(); check("idone_z", 8'(gnt), 8'h00);
        req = 4'b0001;
        step(); check("idone_g", 8'(gnt), 8'b0001);
        step(); check("idone_rel", 8'(gnt), 8'h00);
        done = 1'b0; req = 4'b0;

        // HOLD_MAX=1
        do_reset();
        req1 = 4'b0011;
        step(); check("h1_g0", 8'(gnt1), 8'b0001); check("h1_t0", 8'(timeout1), 8'h00);
        step(); check("h1_z0", 8'(gnt1), 8'h00); check("h1_t1", 8'(timeout1), 8'h01);
        step(); check("h1_g1", 8'(gnt1), 8'b0010); check("h1_t2", 8'(timeout1), 8'h00);
        done1 = 1'b1;
        step(); check("h1_z1", 8'(gnt1), 8'h00); check("h1_t3", 8'(timeout1), 8'h00);
        done1 = 1'b0;
        step(); check("h1_g2", 8'(gnt1), 8'b0001);
        req1 = 4'b0;
        step(); check("h1_z2", 8'(gnt1), 8'h00); check("h1_t4", 8'(timeout1), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
